// File: rtl/hilo_mdu_if.sv
// rtl/hilo_mdu_if.sv - core-side bundle for the HI/LO multiply/divide unit
interface hilo_mdu_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             wr_hi;
    logic             wr_lo;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, flush, wr_hi, wr_lo, wdata,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, a, b, flush, wr_hi, wr_lo, wdata,
        output busy, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/hilo_mdu.sv
// rtl/hilo_mdu.sv - iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers
module hilo_mdu #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic      clk,
    input  logic      reset,
    hilo_mdu_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             is_div;
    logic             res_neg;
    logic             rem_neg;
    logic             dz;
    logic [WIDTH-1:0] opnd;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             busy_q;
    logic             done_q;
    logic             dbz_q;

    logic             is_signed;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

    // Multiply step: acc_hi accumulates, acc_lo holds the multiplier shifting out LSB-first
    logic [WIDTH:0]   mul_sum;
    // Divide step: acc_hi is the partial remainder, acc_lo the dividend turning into the quotient
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] div_diff;

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    always_comb begin
        is_signed = ~bus.op[0];
        a_neg     = is_signed & bus.a[WIDTH-1];
        b_neg     = is_signed & bus.b[WIDTH-1];
        a_mag     = a_neg ? -bus.a : bus.a;
        b_mag     = b_neg ? -bus.b : bus.b;

        mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);

        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, opnd};
        div_diff  = div_shift[WIDTH-1:0] - opnd;

        prod_fix  = res_neg ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
        quo_fix   = res_neg ? -acc_lo : acc_lo;
        rem_fix   = rem_neg ? -acc_hi : acc_hi;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            is_div  <= 1'b0;
            res_neg <= 1'b0;
            rem_neg <= 1'b0;
            dz      <= 1'b0;
            opnd    <= '0;
            acc_hi  <= '0;
            acc_lo  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start && !bus.flush) begin
                        state   <= RUN;
                        cnt     <= CNT_INIT;
                        busy_q  <= 1'b1;
                        dbz_q   <= 1'b0;
                        is_div  <= bus.op[1];
                        res_neg <= a_neg ^ b_neg;
                        rem_neg <= bus.op[1] & a_neg;
                        dz      <= bus.op[1] && (bus.b == '0);
                        opnd    <= bus.op[1] ? b_mag : a_mag;
                        acc_hi  <= '0;
                        acc_lo  <= bus.op[1] ? a_mag : b_mag;
                    end else if (!bus.start) begin
                        if (bus.wr_hi) hi_q <= bus.wdata;
                        if (bus.wr_lo) lo_q <= bus.wdata;
                    end
                end

                RUN: begin
                    if (bus.flush) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else begin
                        if (is_div) begin
                            acc_hi <= div_ge ? div_diff : div_shift[WIDTH-1:0];
                            acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
                        end else begin
                            {acc_hi, acc_lo} <= {mul_sum, acc_lo[WIDTH-1:1]};
                        end
                        cnt <= cnt - CNT_ONE;
                        if (cnt == CNT_ONE) state <= FIX;
                    end
                end

                FIX: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    if (!bus.flush) begin
                        done_q <= 1'b1;
                        if (is_div) begin
                            // A zero divisor leaves acc_hi = |a|, so the signed remainder fix restores a
                            hi_q  <= rem_fix;
                            lo_q  <= dz ? '1 : quo_fix;
                            dbz_q <= dz;
                        end else begin
                            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                            lo_q <= prod_fix[WIDTH-1:0];
                        end
                    end
                end

                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
endmodule
